mpu_store_stream: RTL and testbench

Matrix store engine of the MPU datapath, the read-side counterpart of the element-wise register-file write port. On a store request it selects one matrix register, snapshots all M×N elements in one cycle, then streams them out in row-major order over a valid/ready handshake. Each element carries its (m, n) coordinates and a last flag, in the same element/coordinate format the register file's write port accepts.

---
 rtl/global_defs.sv | 9 +
 rtl/mpu_store_stream.sv | 120 ++++++++++++
 tb/tb_mpu_store_stream.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/global_defs.sv
// Shared MPU datapath dimensions: element width, matrix shape and register-file addressing.
package global_defs;
   localparam int unsigned FP              = 32;
   localparam int unsigned M               = 3;
   localparam int unsigned N               = 3;
   localparam int unsigned MBITS           = $clog2(M);
   localparam int unsigned NBITS           = $clog2(N);
   localparam int unsigned MATRIX_REG_SIZE = 2;
endpackage

// File: rtl/mpu_store_stream.sv
// Matrix store engine: snapshots one register-file matrix and streams it out row-major
// over valid/ready, tagging each element with its (m, n) coordinates and a last flag.
module mpu_store_stream
   import global_defs::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         store_req,
   input  logic [MATRIX_REG_SIZE-1:0]   store_addr,
   output logic                         idle,
   output logic [MATRIX_REG_SIZE-1:0]   matrix_addr,
   input  logic [M-1:0][N-1:0][FP-1:0]  matrix_in,
   output logic [FP-1:0]                element_out,
   output logic [MBITS:0]               m_out,
   output logic [NBITS:0]               n_out,
   output logic                         valid_out,
   output logic                         last_out,
   input  logic                         ready_in,
   output logic                         done
);
   localparam int unsigned MW = MBITS + 1;
   localparam int unsigned NW = NBITS + 1;
   localparam logic [MW-1:0] M_LAST = MW'(M - 1);
   localparam logic [NW-1:0] N_LAST = NW'(N - 1);

   typedef enum logic [1:0] {IDLE, FETCH, STREAM, DONE} state_t;

   state_t                         state, state_nx;
   logic [M-1:0][N-1:0][FP-1:0]    snap_q;
   logic [MATRIX_REG_SIZE-1:0]     addr_nx;
   logic [FP-1:0]                  elem_nx;
   logic [MW-1:0]                  m_nx;
   logic [NW-1:0]                  n_nx;
   logic                           valid_nx;
   logic                           last_nx;
   logic                           done_nx;

   assign idle = (state == IDLE);

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         matrix_addr <= '0;
         element_out <= '0;
         m_out       <= '0;
         n_out       <= '0;
         valid_out   <= 1'b0;
         last_out    <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_nx;
         matrix_addr <= addr_nx;
         element_out <= elem_nx;
         m_out       <= m_nx;
         n_out       <= n_nx;
         valid_out   <= valid_nx;
         last_out    <= last_nx;
         done        <= done_nx;
      end
   end

   // Snapshot buffer; later register-file writes cannot reach the stream.
   always_ff @(posedge clk) begin
      if (state == FETCH) snap_q <= matrix_in;
   end

   // Next-state and next-output decode.
   always_comb begin
      state_nx = state;
      addr_nx  = matrix_addr;
      elem_nx  = element_out;
      m_nx     = m_out;
      n_nx     = n_out;
      valid_nx = valid_out;
      last_nx  = last_out;
      done_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (store_req) begin
               addr_nx  = store_addr;
               state_nx = FETCH;
            end
         end
         FETCH: begin
            elem_nx  = matrix_in[0][0];
            m_nx     = '0;
            n_nx     = '0;
            valid_nx = 1'b1;
            last_nx  = (M_LAST == '0) && (N_LAST == '0);
            state_nx = STREAM;
         end
         STREAM: begin
            if (ready_in) begin
               if (last_out) begin
                  valid_nx = 1'b0;
                  last_nx  = 1'b0;
                  done_nx  = 1'b1;
                  state_nx = DONE;
               end else begin
                  if (n_out < N_LAST) begin
                     n_nx = n_out + NW'(1);
                  end else begin
                     n_nx = '0;
                     m_nx = m_out + MW'(1);
                  end
                  elem_nx = snap_q[m_nx[MBITS-1:0]][n_nx[NBITS-1:0]];
                  last_nx = (m_nx == M_LAST) && (n_nx == N_LAST);
               end
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_mpu_store_stream.sv
// Bench for mpu_store_stream: transaction-level queue model checked every cycle,
// plus directed scenarios with hand-computed cycle numbers and element values.
module tb_mpu_store_stream;
   import global_defs::*;

   logic                         clk = 1'b0;
   logic                         rst = 1'b1;
   logic                         store_req = 1'b0;
   logic [MATRIX_REG_SIZE-1:0]   store_addr = '0;
   logic                         ready_in = 1'b0;
   logic                         idle;
   logic [MATRIX_REG_SIZE-1:0]   matrix_addr;
   logic [M-1:0][N-1:0][FP-1:0]  matrix_in;
   logic [FP-1:0]                element_out;
   logic [MBITS:0]               m_out;
   logic [NBITS:0]               n_out;
   logic                         valid_out;
   logic                         last_out;
   logic                         done;

   logic [M-1:0][N-1:0][FP-1:0]  regs [4];

   mpu_store_stream dut (
      .clk(clk), .rst(rst), .store_req(store_req), .store_addr(store_addr),
      .idle(idle), .matrix_addr(matrix_addr), .matrix_in(matrix_in),
      .element_out(element_out), .m_out(m_out), .n_out(n_out),
      .valid_out(valid_out), .last_out(last_out), .ready_in(ready_in), .done(done)
   );

   // Register-file read port: combinational from matrix_addr.
   assign matrix_in = regs[matrix_addr];

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: a store is a queue of beats filled from the register file one cycle after acceptance.
   typedef struct packed {
      logic [31:0] e;
      int          m;
      int          n;
   } beat_t;

   beat_t                      exp_q[$];
   bit                         mb_busy  = 1'b0;
   bit                         mb_fetch = 1'b0;
   bit                         mb_done  = 1'b0;
   logic [MATRIX_REG_SIZE-1:0] mb_addr  = '0;

   always @(posedge clk) begin
      if (rst) begin
         mb_busy = 1'b0; mb_fetch = 1'b0; mb_done = 1'b0; mb_addr = '0;
         exp_q.delete();
      end else if (mb_done) begin
         mb_done = 1'b0;
         mb_busy = 1'b0;
      end else if (mb_fetch) begin
         mb_fetch = 1'b0;
         for (int i = 0; i < int'(M); i++)
            for (int j = 0; j < int'(N); j++)
               exp_q.push_back('{e: regs[mb_addr][i][j], m: i, n: j});
      end else if (mb_busy && exp_q.size() != 0 && ready_in) begin
         void'(exp_q.pop_front());
         if (exp_q.size() == 0) mb_done = 1'b1;
      end else if (!mb_busy && store_req) begin
         mb_busy  = 1'b1;
         mb_fetch = 1'b1;
         mb_addr  = store_addr;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("idle", 64'(idle), 64'(!mb_busy));
         check("matrix_addr", 64'(matrix_addr), 64'(mb_addr));
         check("done", 64'(done), 64'(mb_done));
         check("valid_out", 64'(valid_out), 64'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            check("element_out", 64'(element_out), 64'(exp_q[0].e));
            check("m_out", 64'(m_out), 64'(exp_q[0].m));
            check("n_out", 64'(n_out), 64'(exp_q[0].n));
            check("last_out", 64'(last_out), 64'(exp_q.size() == 1));
         end else begin
            check("last_out_idle", 64'(last_out), 64'd0);
         end
      end
   end

   int          beats, first_v, hs_last, done_c, idle_c, lasts;
   logic [31:0] e11, first_e, last_e;

   // Issues a store at edge 0; cycle k is the cycle after edge k-1.
   task automatic run_store(input logic [MATRIX_REG_SIZE-1:0] a, input int pat,
                            input int wr_at, input int req_at);
      @(negedge clk);
      store_addr = a; store_req = 1'b1; ready_in = 1'b1;
      beats = 0; first_v = -1; hs_last = -1; done_c = -1; idle_c = -1; lasts = 0;
      e11 = '0; first_e = '0; last_e = '0;
      for (int k = 1; k <= 60 && idle_c < 0; k++) begin
         @(negedge clk);
         store_req  = (k == req_at);
         store_addr = (k == req_at) ? MATRIX_REG_SIZE'(3) : a;
         ready_in   = (pat == 0) || ((k + 1) % 3 == 0);
         if (k == wr_at) regs[a][1][1] = 32'hDEAD_BEEF;
         if (valid_out && first_v < 0) begin first_v = k; first_e = element_out; end
         if (valid_out && m_out == 1 && n_out == 1) e11 = element_out;
         if (valid_out && ready_in) begin
            beats++; hs_last = k; last_e = element_out;
            if (last_out) lasts++;
         end
         if (done && done_c < 0) done_c = k;
         if (idle && done_c >= 0) idle_c = k;
      end
      if (idle_c < 0) check("store_timeout", 64'(idle), 64'd1);
      store_req = 1'b0;
   endtask

   int hs, dones, fetches, fetch2;

   initial begin
      for (int r = 0; r < 4; r++)
         for (int i = 0; i < int'(M); i++)
            for (int j = 0; j < int'(N); j++)
               regs[r][i][j] = 32'h3E00_0000 + 32'(r) * 32'h0100_0000 + 32'(3 * i + j);

      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      check("rst_idle", 64'(idle), 64'd1);
      check("rst_valid", 64'(valid_out), 64'd0);
      check("rst_addr", 64'(matrix_addr), 64'd0);
      check("rst_elem", 64'(element_out), 64'd0);
      check("rst_mn", 64'({m_out, n_out}), 64'd0);
      check("rst_done_last", 64'({done, last_out}), 64'd0);

      // Full-rate store of reg 2.
      run_store(MATRIX_REG_SIZE'(2), 0, -1, -1);
      check("t1_first_valid_cyc", 64'(first_v), 64'd2);
      check("t1_first_elem", 64'(first_e), 64'h4000_0000);
      check("t1_last_elem", 64'(last_e), 64'h4000_0008);
      check("t1_beats", 64'(beats), 64'd9);
      check("t1_lasts", 64'(lasts), 64'd1);
      check("t1_last_hs_cyc", 64'(hs_last), 64'd10);
      check("t1_done_cyc", 64'(done_c), 64'd11);
      check("t1_idle_cyc", 64'(idle_c), 64'd12);

      // Throttled consumer: ready 1,0,0 repeating from cycle 2.
      run_store(MATRIX_REG_SIZE'(2), 1, -1, -1);
      check("t2_beats", 64'(beats), 64'd9);
      check("t2_last_hs_cyc", 64'(hs_last), 64'd26);
      check("t2_done_cyc", 64'(done_c), 64'd27);
      check("t2_last_elem", 64'(last_e), 64'h4000_0008);

      // Register write during STREAM must not reach the stream.
      run_store(MATRIX_REG_SIZE'(1), 0, 4, -1);
      check("t3_snapshot_e11", 64'(e11), 64'h3F00_0004);
      check("t3_beats", 64'(beats), 64'd9);

      // Store request during STREAM is ignored.
      run_store(MATRIX_REG_SIZE'(0), 0, -1, 5);
      check("t4_beats", 64'(beats), 64'd9);
      check("t4_first_elem", 64'(first_e), 64'h3E00_0000);
      check("t4_matrix_addr", 64'(matrix_addr), 64'd0);

      // Reset after the 4th handshake abandons the stream.
      @(negedge clk);
      store_addr = MATRIX_REG_SIZE'(2); store_req = 1'b1; ready_in = 1'b1;
      hs = 0;
      for (int k = 1; k <= 10 && hs < 4; k++) begin
         @(negedge clk);
         store_req = 1'b0;
         if (valid_out && ready_in) hs++;
      end
      check("t5_hs_reached", 64'(hs), 64'd4);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5_valid_after_rst", 64'(valid_out), 64'd0);
      check("t5_idle_after_rst", 64'(idle), 64'd1);
      dones = 0;
      for (int k = 0; k < 15; k++) begin
         if (done) dones++;
         @(negedge clk);
      end
      check("t5_no_done", 64'(dones), 64'd0);
      run_store(MATRIX_REG_SIZE'(2), 0, -1, -1);
      check("t5_restart_first_elem", 64'(first_e), 64'h4000_0000);
      check("t5_restart_beats", 64'(beats), 64'd9);

      // store_req held high across two back-to-back stores.
      @(negedge clk);
      store_addr = MATRIX_REG_SIZE'(2); store_req = 1'b1; ready_in = 1'b1;
      fetches = 0; dones = 0; beats = 0; fetch2 = -1;
      for (int k = 1; k <= 26; k++) begin
         @(negedge clk);
         store_req = (k <= 12);
         if (!idle && !valid_out && !done) begin
            fetches++;
            if (fetches == 2) fetch2 = k;
         end
         if (valid_out && ready_in) beats++;
         if (done) dones++;
      end
      store_req = 1'b0;
      check("t6_fetches", 64'(fetches), 64'd2);
      check("t6_second_fetch_cyc", 64'(fetch2), 64'd13);
      check("t6_beats", 64'(beats), 64'd18);
      check("t6_dones", 64'(dones), 64'd2);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
